// File: rtl/pa_ahbl_pkg.sv
// Shared AHB-Lite encodings and responder state type for the SRAM slave.
package pa_ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  function automatic logic [3:0] size_to_be(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lsb;
      HSIZE_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/pa_ahbl_slv_dec.sv
// Address-phase decode: byte enables, alignment/size legality and window check.
module pa_ahbl_slv_dec
  import pa_ahbl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WIN_AW    = 16
) (
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  output logic [3:0]  be,
  output logic        err
);

  logic out_of_win;
  logic bad_size;
  logic misaligned;
  logic unused_addr;

  always_comb begin
    out_of_win = (haddr[31:WIN_AW] != BASE_ADDR[31:WIN_AW]);
    bad_size   = (hsize > HSIZE_WORD);
    misaligned = ((hsize == HSIZE_HALF) && haddr[0]) ||
                 ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    err        = out_of_win | bad_size | misaligned;
    be         = size_to_be(hsize, haddr[1:0]);
  end

  // Word-address bits are consumed by the top-level register, not here.
  assign unused_addr = ^haddr[WIN_AW-1:2];

endmodule

// File: rtl/pa_ahbl_slv_sram.sv
// AHB-Lite responder bridging bus transfers onto a single-port memory req/ack
// interface, with ack-driven wait states and two-cycle ERROR responses.
module pa_ahbl_slv_sram
  import pa_ahbl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WIN_AW    = 16
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              pad_ahbl_hsel,
  input  logic [31:0]       pad_ahbl_haddr,
  input  logic [1:0]        pad_ahbl_htrans,
  input  logic              pad_ahbl_hwrite,
  input  logic [2:0]        pad_ahbl_hsize,
  input  logic [2:0]        pad_ahbl_hburst,
  input  logic [3:0]        pad_ahbl_hprot,
  input  logic [31:0]       pad_ahbl_hwdata,
  input  logic              pad_ahbl_hready,
  output logic              ahbl_pad_hreadyout,
  output logic              ahbl_pad_hresp,
  output logic [31:0]       ahbl_pad_hrdata,
  output logic              slv_mem_req,
  output logic              slv_mem_wen,
  output logic [WIN_AW-3:0] slv_mem_addr,
  output logic [3:0]        slv_mem_be,
  output logic [31:0]       slv_mem_wdata,
  input  logic              mem_slv_ack,
  input  logic [31:0]       mem_slv_rdata,
  output logic              ahbl_slv_idle
);

  slv_state_e        state_q, state_d;
  logic [WIN_AW-3:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic              wen_q, wen_d;
  logic [2:0]        size_q, size_d;
  logic              err_q, err_d;

  logic [3:0] dec_be;
  logic       dec_err;
  logic       accept;
  logic       can_take;
  logic       take;
  logic       unused_sig;

  pa_ahbl_slv_dec #(
    .BASE_ADDR (BASE_ADDR),
    .WIN_AW    (WIN_AW)
  ) u_dec (
    .haddr (pad_ahbl_haddr),
    .hsize (pad_ahbl_hsize),
    .be    (dec_be),
    .err   (dec_err)
  );

  assign accept = pad_ahbl_hsel & pad_ahbl_htrans[1] & pad_ahbl_hready;

  // A new address phase may only land where the current data phase ends.
  always_comb begin
    can_take = 1'b0;
    case (state_q)
      ST_IDLE: can_take = 1'b1;
      ST_ACC:  can_take = mem_slv_ack;
      ST_ERR1: can_take = 1'b0;
      ST_ERR2: can_take = 1'b1;
      default: can_take = 1'b0;
    endcase
    take = accept & can_take;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wen_d   = wen_q;
    size_d  = size_q;
    err_d   = err_q;
    if (take) begin
      addr_d = pad_ahbl_haddr[WIN_AW-1:2];
      be_d   = dec_be;
      wen_d  = pad_ahbl_hwrite;
      size_d = pad_ahbl_hsize;
      err_d  = dec_err;
    end
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (take) state_d = dec_err ? ST_ERR1 : ST_ACC;
        else      state_d = ST_IDLE;
      end
      ST_ACC: begin
        if (mem_slv_ack) begin
          if (take) state_d = dec_err ? ST_ERR1 : ST_ACC;
          else      state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ahbl_pad_hreadyout = 1'b1;
    ahbl_pad_hresp     = HRESP_OKAY;
    ahbl_pad_hrdata    = '0;
    slv_mem_req        = 1'b0;
    slv_mem_wdata      = '0;
    case (state_q)
      ST_ACC: begin
        slv_mem_req        = 1'b1;
        slv_mem_wdata      = pad_ahbl_hwdata;
        ahbl_pad_hreadyout = mem_slv_ack;
        if (!wen_q && mem_slv_ack) ahbl_pad_hrdata = mem_slv_rdata;
      end
      ST_ERR1: begin
        ahbl_pad_hreadyout = 1'b0;
        ahbl_pad_hresp     = HRESP_ERR;
      end
      ST_ERR2: begin
        ahbl_pad_hreadyout = 1'b1;
        ahbl_pad_hresp     = HRESP_ERR;
      end
      default: ;
    endcase
  end

  assign slv_mem_wen   = wen_q;
  assign slv_mem_addr  = addr_q;
  assign slv_mem_be    = be_q;
  assign ahbl_slv_idle = (state_q == ST_IDLE);

  // Burst/protection hints and the captured size/error are informational only.
  assign unused_sig = ^{pad_ahbl_hburst, pad_ahbl_hprot, size_q, err_q};

endmodule

// File: tb/tb_pa_ahbl_slv_sram.sv
// Directed bench for pa_ahbl_slv_sram: one task per scenario, inline checks.
module tb_pa_ahbl_slv_sram;

  logic        clk;
  logic        rst_b;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_req;
  logic        mem_wen;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        idle;

  int errors = 0;
  int checks = 0;

  pa_ahbl_slv_sram #(.BASE_ADDR(32'h0000_0000), .WIN_AW(16)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_b),
    .pad_ahbl_hsel      (hsel),
    .pad_ahbl_haddr     (haddr),
    .pad_ahbl_htrans    (htrans),
    .pad_ahbl_hwrite    (hwrite),
    .pad_ahbl_hsize     (hsize),
    .pad_ahbl_hburst    (hburst),
    .pad_ahbl_hprot     (hprot),
    .pad_ahbl_hwdata    (hwdata),
    .pad_ahbl_hready    (hready),
    .ahbl_pad_hreadyout (hreadyout),
    .ahbl_pad_hresp     (hresp),
    .ahbl_pad_hrdata    (hrdata),
    .slv_mem_req        (mem_req),
    .slv_mem_wen        (mem_wen),
    .slv_mem_addr       (mem_addr),
    .slv_mem_be         (mem_be),
    .slv_mem_wdata      (mem_wdata),
    .mem_slv_ack        (mem_ack),
    .mem_slv_rdata      (mem_rdata),
    .ahbl_slv_idle      (idle)
  );

  // Single-slave bus: HREADY is the slave's own HREADYOUT.
  assign hready = hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a);
    hsel = sel; htrans = trans; hwrite = wr; hsize = sz; haddr = a;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got=%b exp=1", hreadyout); end
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp got=%b exp=0", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", idle); end
    checks++; if (mem_addr !== 14'h0 || mem_be !== 4'h0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL rst_fields got addr=%h be=%h wen=%b exp 0/0/0", mem_addr, mem_be, mem_wen); end
    #2 rst_b = 1'b1;
  endtask

  task automatic test_write_read();
    next_cycle();
    drive(1'b1, 2'b10, 1'b1, 3'd2, 32'h10); mem_ack = 1'b0;
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0); hwdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL wr_wait got=%b exp=0", hreadyout); end
    checks++; if (mem_req !== 1'b1 || mem_wen !== 1'b1) begin errors++; $display("FAIL wr_req got req=%b wen=%b exp 1/1", mem_req, mem_wen); end
    checks++; if (mem_be !== 4'hF || mem_addr !== 14'h4) begin errors++; $display("FAIL wr_be_addr got be=%h addr=%h exp F/4", mem_be, mem_addr); end
    checks++; if (mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_wdata got=%h exp=12345678", mem_wdata); end
    next_cycle();
    mem_ack = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h10);
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL wr_done got=%b exp=1", hreadyout); end
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0); mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL rd_zero_wait got rdy=%b resp=%b exp 1/0", hreadyout, hresp); end
    checks++; if (hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", hrdata); end
    checks++; if (mem_wen !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL rd_req got wen=%b req=%b exp 0/1", mem_wen, mem_req); end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (idle !== 1'b1 || hrdata !== 32'h0) begin errors++; $display("FAIL rd_back_idle got idle=%b hrdata=%h exp 1/0", idle, hrdata); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] a_tab [5] = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h2};
    logic [2:0]  s_tab [5] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [3:0]  b_tab [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1'b1, 2'b10, 1'b1, s_tab[i], a_tab[i]); mem_ack = 1'b1;
      next_cycle();
      drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0);
      @(negedge clk);
      checks++; if (mem_be !== b_tab[i] || mem_req !== 1'b1) begin
        errors++; $display("FAIL be[%0d] got be=%b req=%b exp be=%b req=1", i, mem_be, mem_req, b_tab[i]); end
    end
    next_cycle();
    mem_ack = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] a_tab [4] = '{32'h1, 32'h2, 32'h0, 32'h0001_0000};
    logic [2:0]  s_tab [4] = '{3'd1, 3'd2, 3'd3, 3'd2};
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b1, 2'b10, 1'b0, s_tab[i], a_tab[i]);
      next_cycle();
      drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h40);
      @(negedge clk);
      checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL err1[%0d] got rdy=%b resp=%b req=%b exp 0/1/0", i, hreadyout, hresp, mem_req); end
      next_cycle();
      drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0);
      @(negedge clk);
      checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL err2[%0d] got rdy=%b resp=%b req=%b exp 1/1/0", i, hreadyout, hresp, mem_req); end
      next_cycle();
      @(negedge clk);
      checks++; if (idle !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL err_ignored[%0d] got idle=%b req=%b exp 1/0", i, idle, mem_req); end
    end
    next_cycle();
    drive(1'b1, 2'b10, 1'b1, 3'd3, 32'h0);
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0);
    next_cycle();
    drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h20);
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0); mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h8 || hresp !== 1'b0 || hrdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL err2_accept got req=%b addr=%h resp=%b rd=%h exp 1/8/0/cafef00d", mem_req, mem_addr, hresp, hrdata); end
    next_cycle();
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h100); mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i < 3) drive(1'b1, 2'b11, 1'b0, 3'd2, 32'h100 + 32'(4 * (i + 1)));
      else       drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0);
      mem_rdata = 32'hA0 + 32'(i);
      @(negedge clk);
      checks++; if (hreadyout !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 14'(16'h40 + i) || hrdata !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL b2b[%0d] got rdy=%b req=%b addr=%h rd=%h exp 1/1/%h/%h", i, hreadyout, mem_req, mem_addr, hrdata, 16'h40 + i, 32'hA0 + i); end
    end
    next_cycle();
    mem_ack = 1'b0;
    drive(1'b1, 2'b01, 1'b0, 3'd2, 32'h0);
    next_cycle();
    drive(1'b1, 2'b00, 1'b1, 3'd2, 32'h4);
    @(negedge clk);
    checks++; if (idle !== 1'b1 || mem_req !== 1'b0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
      errors++; $display("FAIL busy_okay got idle=%b req=%b rdy=%b resp=%b exp 1/0/1/0", idle, mem_req, hreadyout, hresp); end
    next_cycle();
    drive(1'b0, 2'b10, 1'b1, 3'd2, 32'h8);
    @(negedge clk);
    checks++; if (idle !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_okay got idle=%b req=%b exp 1/0", idle, mem_req); end
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checks++; if (idle !== 1'b1 || mem_req !== 1'b0 || hreadyout !== 1'b1) begin
      errors++; $display("FAIL nosel_okay got idle=%b req=%b rdy=%b exp 1/0/1", idle, mem_req, hreadyout); end
  endtask

  task automatic test_wait_states();
    next_cycle();
    drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h24); mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1'b1, 2'b10, 1'b1, 3'd0, 32'h3);
      @(negedge clk);
      checks++; if (hreadyout !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 14'h9 || mem_be !== 4'hF || mem_wen !== 1'b0) begin
        errors++; $display("FAIL wait[%0d] got rdy=%b req=%b addr=%h be=%h wen=%b exp 0/1/9/f/0", i, hreadyout, mem_req, mem_addr, mem_be, mem_wen); end
    end
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0); mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1 || hrdata !== 32'h55AA_55AA) begin
      errors++; $display("FAIL wait_done got rdy=%b rd=%h exp 1/55aa55aa", hreadyout, hrdata); end
    next_cycle();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    next_cycle();
    drive(1'b1, 2'b10, 1'b1, 3'd2, 32'h30); mem_ack = 1'b0;
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_acc_pre got req=%b exp=1", mem_req); end
    rst_b = 1'b0;
    #1;
    checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || mem_req !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL rst_acc got rdy=%b resp=%b req=%b idle=%b exp 1/0/0/1", hreadyout, hresp, mem_req, idle); end
    #2 rst_b = 1'b1;
    next_cycle();
    drive(1'b1, 2'b10, 1'b0, 3'd3, 32'h0);
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd0, 32'h0);
    #1;
    checks++; if (hresp !== 1'b1 || hreadyout !== 1'b0) begin
      errors++; $display("FAIL rst_err1_pre got resp=%b rdy=%b exp 1/0", hresp, hreadyout); end
    rst_b = 1'b0;
    #1;
    checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || mem_req !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL rst_err1 got rdy=%b resp=%b req=%b idle=%b exp 1/0/0/1", hreadyout, hresp, mem_req, idle); end
    #1 rst_b = 1'b1;
    @(negedge clk);
    checks++; if (idle !== 1'b1 || hresp !== 1'b0) begin
      errors++; $display("FAIL rst_after got idle=%b resp=%b exp 1/0", idle, hresp); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
